// File: rtl/lsu_port.sv
// lsu_port: RV32I load/store port between a CPU request interface and a
// single-cycle-latency word memory. Byte and halfword stores are done as
// read-modify-write of the containing word.
// Optional feature: define LSU_MISALIGN_TRAP_EN to reject misaligned
// halfword/word accesses. Without it, the address bits below natural
// alignment are ignored.
module lsu_port #(
   parameter int MEM_BYTES = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic [31:0] mem_addr,
   output logic        mem_ren,
   output logic        mem_wen,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      READ  = 3'd1,
      WAIT  = 3'd2,
      WRITE = 3'd3,
      RESP  = 3'd4
   } state_t;

   state_t      state_r, state_s;
   logic        we_r, we_s;
   logic [2:0]  funct3_r, funct3_s;
   logic [31:0] addr_r, addr_s;
   logic [31:0] wdata_r, wdata_s;
   logic [31:0] word_r, word_s;

   logic        req_ready_s, rsp_valid_s, rsp_err_s, mem_ren_s, mem_wen_s;
   logic [31:0] rsp_rdata_s, mem_addr_s;

   logic        f3_legal_s, misalign_s, req_err_s;
   logic [32:0] size_s, end_s;

   // Extract and extend the addressed byte/halfword of a loaded word.
   function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                input logic [2:0]  f3,
                                                input logic [1:0]  a);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      case (a)
         2'd0:    b = word[7:0];
         2'd1:    b = word[15:8];
         2'd2:    b = word[23:16];
         2'd3:    b = word[31:24];
         default: b = 8'd0;
      endcase
      h = a[1] ? word[31:16] : word[15:0];
      case (f3)
         3'd0:    r = {{24{b[7]}}, b};
         3'd1:    r = {{16{h[15]}}, h};
         3'd2:    r = word;
         3'd4:    r = {24'd0, b};
         3'd5:    r = {16'd0, h};
         default: r = 32'd0;
      endcase
      return r;
   endfunction

   // Replace the addressed byte/halfword lane of a word with store data.
   function automatic logic [31:0] store_merge(input logic [31:0] word,
                                               input logic [2:0]  f3,
                                               input logic [1:0]  a,
                                               input logic [31:0] wd);
      logic [31:0] r;
      r = word;
      case (f3)
         3'd0: begin
            case (a)
               2'd0:    r[7:0]   = wd[7:0];
               2'd1:    r[15:8]  = wd[7:0];
               2'd2:    r[23:16] = wd[7:0];
               2'd3:    r[31:24] = wd[7:0];
               default: r = word;
            endcase
         end
         3'd1: begin
            if (a[1]) begin
               r[31:16] = wd[15:0];
            end else begin
               r[15:0] = wd[15:0];
            end
         end
         3'd2:    r = wd;
         default: r = word;
      endcase
      return r;
   endfunction

   // Classify the incoming request: legal width code, range and alignment.
   always_comb begin
      case (req_funct3[1:0])
         2'd0:    size_s = 33'd1;
         2'd1:    size_s = 33'd2;
         2'd2:    size_s = 33'd4;
         default: size_s = 33'd4;
      endcase
      if (req_we) begin
         f3_legal_s = (req_funct3 == 3'd0) || (req_funct3 == 3'd1) || (req_funct3 == 3'd2);
      end else begin
         f3_legal_s = (req_funct3 != 3'd3) && (req_funct3 != 3'd6) && (req_funct3 != 3'd7);
      end
      end_s = {1'b0, req_addr} + size_s;
`ifdef LSU_MISALIGN_TRAP_EN
      misalign_s = ((req_funct3[1:0] == 2'd1) && req_addr[0]) ||
                   ((req_funct3[1:0] == 2'd2) && (req_addr[1:0] != 2'b00));
`else
      misalign_s = 1'b0;
`endif
      req_err_s = !f3_legal_s ||
                  ({1'b0, req_addr} >= 33'(MEM_BYTES)) ||
                  (end_s > 33'(MEM_BYTES)) ||
                  misalign_s;
   end

   // Next-state and next-output decode; every output is loaded into a register.
   always_comb begin
      state_s     = state_r;
      we_s        = we_r;
      funct3_s    = funct3_r;
      addr_s      = addr_r;
      wdata_s     = wdata_r;
      word_s      = word_r;
      req_ready_s = 1'b0;
      rsp_valid_s = 1'b0;
      rsp_err_s   = 1'b0;
      rsp_rdata_s = 32'd0;
      mem_addr_s  = 32'd0;
      mem_ren_s   = 1'b0;
      mem_wen_s   = 1'b0;
      case (state_r)
         IDLE: begin
            if (req_valid && req_ready) begin
               we_s     = req_we;
               funct3_s = req_funct3;
               addr_s   = req_addr;
               wdata_s  = req_wdata;
               if (req_err_s) begin
                  state_s     = RESP;
                  rsp_valid_s = 1'b1;
                  rsp_err_s   = 1'b1;
               end else if (req_we && (req_funct3 == 3'd2)) begin
                  state_s    = WRITE;
                  mem_wen_s  = 1'b1;
                  mem_addr_s = {req_addr[31:2], 2'b00};
                  word_s     = req_wdata;
               end else begin
                  state_s    = READ;
                  mem_ren_s  = 1'b1;
                  mem_addr_s = {req_addr[31:2], 2'b00};
               end
            end else begin
               req_ready_s = 1'b1;
            end
         end
         READ: begin
            state_s = WAIT;
         end
         WAIT: begin
            if (we_r) begin
               state_s    = WRITE;
               mem_wen_s  = 1'b1;
               mem_addr_s = {addr_r[31:2], 2'b00};
               word_s     = store_merge(mem_rdata, funct3_r, addr_r[1:0], wdata_r);
            end else begin
               state_s     = RESP;
               rsp_valid_s = 1'b1;
               rsp_rdata_s = load_extract(mem_rdata, funct3_r, addr_r[1:0]);
               word_s      = mem_rdata;
            end
         end
         WRITE: begin
            state_s     = RESP;
            rsp_valid_s = 1'b1;
         end
         RESP: begin
            state_s     = IDLE;
            req_ready_s = 1'b1;
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r   <= IDLE;
         we_r      <= 1'b0;
         funct3_r  <= 3'd0;
         addr_r    <= 32'd0;
         wdata_r   <= 32'd0;
         word_r    <= 32'd0;
         req_ready <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_rdata <= 32'd0;
         mem_addr  <= 32'd0;
         mem_ren   <= 1'b0;
         mem_wen   <= 1'b0;
      end else begin
         state_r   <= state_s;
         we_r      <= we_s;
         funct3_r  <= funct3_s;
         addr_r    <= addr_s;
         wdata_r   <= wdata_s;
         word_r    <= word_s;
         req_ready <= req_ready_s;
         rsp_valid <= rsp_valid_s;
         rsp_err   <= rsp_err_s;
         rsp_rdata <= rsp_rdata_s;
         mem_addr  <= mem_addr_s;
         mem_ren   <= mem_ren_s;
         mem_wen   <= mem_wen_s;
      end
   end

   // The data word register doubles as the write-data output.
   assign mem_wdata = word_r;

endmodule

// File: tb/tb_lsu_port.sv
// Scoreboard bench for lsu_port: stimulus pushes expected responses and
// writes into queues; a negedge monitor pops and compares them.
module tb_lsu_port;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_ready, req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr, req_wdata;
   logic        rsp_valid, rsp_err;
   logic [31:0] rsp_rdata;
   logic [31:0] mem_addr, mem_wdata;
   logic        mem_ren, mem_wen;
   logic [31:0] mem_rdata;

   logic [31:0] mem [0:15];

   typedef struct {
      string       name;
      logic [31:0] rdata;
      logic        err;
      int          due;
   } rsp_t;

   typedef struct {
      string       name;
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   rsp_t        rq[$];
   wr_t         wq[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          ren_cnt = 0;
   logic [31:0] exp_raddr = 32'd0;

   lsu_port #(.MEM_BYTES(64)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .mem_addr(mem_addr), .mem_ren(mem_ren), .mem_wen(mem_wen),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Memory model: one-cycle read latency, full-word writes.
   always @(posedge clk) begin
      if (mem_ren) mem_rdata <= mem[mem_addr[5:2]];
      if (mem_wen) mem[mem_addr[5:2]] <= mem_wdata;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Monitor: compare responses, read addresses and writes against the queues.
   always @(negedge clk) begin
      if (rsp_valid) begin
         if (rq.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_rsp actual rdata=%h err=%b expected no response", rsp_rdata, rsp_err);
         end else begin
            rsp_t e;
            e = rq.pop_front();
            chk({e.name, "_rdata"}, rsp_rdata, e.rdata);
            chk({e.name, "_err"}, {31'd0, rsp_err}, {31'd0, e.err});
            chk({e.name, "_latency"}, cyc, e.due);
         end
      end
      if (mem_ren) begin
         ren_cnt++;
         chk("ren_addr", mem_addr, exp_raddr);
      end
      if (mem_wen) begin
         if (wq.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_wen actual addr=%h data=%h expected no write", mem_addr, mem_wdata);
         end else begin
            wr_t w;
            w = wq.pop_front();
            chk({w.name, "_waddr"}, mem_addr, w.addr);
            chk({w.name, "_wdata"}, mem_wdata, w.data);
         end
      end
   end

   task automatic wait_ready(output bit ok);
      ok = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 10 && !req_ready; i++) @(negedge clk);
      if (!req_ready) begin
         checks++; errors++; ok = 1'b0;
         $display("FAIL ready_timeout actual req_ready=0 expected 1");
      end
   endtask

   task automatic issue(input string name, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_err, input int lat,
                        input int exp_reads, input bit exp_wr, input logic [31:0] exp_wd);
      bit   ok;
      int   acc, ren0;
      rsp_t e;
      wr_t  w;
      wait_ready(ok);
      if (ok) begin
         ren0       = ren_cnt;
         exp_raddr  = {addr[31:2], 2'b00};
         req_valid  = 1'b1;
         req_we     = we;
         req_funct3 = f3;
         req_addr   = addr;
         req_wdata  = wd;
         @(posedge clk);
         #1;
         acc       = cyc;
         req_valid = 1'b0;
         e.name = name; e.rdata = exp_rd; e.err = exp_err; e.due = acc + lat - 1;
         rq.push_back(e);
         if (exp_wr) begin
            w.name = name; w.addr = {addr[31:2], 2'b00}; w.data = exp_wd;
            wq.push_back(w);
         end
         for (int i = 0; i < 20 && (rq.size() != 0 || wq.size() != 0); i++) begin
            @(negedge clk);
            #1;
         end
         if (rq.size() != 0 || wq.size() != 0) begin
            checks++; errors++;
            $display("FAIL %s_timeout actual pending rsp=%0d wr=%0d expected 0", name, rq.size(), wq.size());
            rq.delete();
            wq.delete();
         end
         chk({name, "_reads"}, ren_cnt - ren0, exp_reads);
      end
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk({tag, "_req_ready"}, {31'd0, req_ready}, 32'd0);
      chk({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
      chk({tag, "_rsp_err"},   {31'd0, rsp_err},   32'd0);
      chk({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
      chk({tag, "_mem_addr"},  mem_addr,  32'd0);
      chk({tag, "_mem_ren"},   {31'd0, mem_ren},   32'd0);
      chk({tag, "_mem_wen"},   {31'd0, mem_wen},   32'd0);
      chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      for (int i = 0; i < 16; i++) mem[i] = 32'd0;
      mem[4]     = 32'h8000_00F0;
      mem[8]     = 32'h1122_3344;
      mem_rdata  = 32'd0;
      rst_n      = 1'b0;
      req_valid  = 1'b0;
      req_we     = 1'b0;
      req_funct3 = 3'd0;
      req_addr   = 32'd0;
      req_wdata  = 32'd0;

      repeat (3) @(negedge clk);
      #1;
      chk_outputs_zero("reset");
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      chk("reset_ready_rise", {31'd0, req_ready}, 32'd1);

      // loads
      issue("lb_10",  1'b0, 3'd0, 32'h10, 32'd0, 32'hFFFF_FFF0, 1'b0, 3, 1, 1'b0, 32'd0);
      issue("lbu_10", 1'b0, 3'd4, 32'h10, 32'd0, 32'h0000_00F0, 1'b0, 3, 1, 1'b0, 32'd0);
      issue("lhu_12", 1'b0, 3'd5, 32'h12, 32'd0, 32'h0000_8000, 1'b0, 3, 1, 1'b0, 32'd0);
      issue("lh_12",  1'b0, 3'd1, 32'h12, 32'd0, 32'hFFFF_8000, 1'b0, 3, 1, 1'b0, 32'd0);
      issue("lw_10",  1'b0, 3'd2, 32'h10, 32'd0, 32'h8000_00F0, 1'b0, 3, 1, 1'b0, 32'd0);
      // read-modify-write stores
      issue("sb_21",  1'b1, 3'd0, 32'h21, 32'h0000_00AB, 32'd0, 1'b0, 4, 1, 1'b1, 32'h1122_AB44);
      issue("lw_20",  1'b0, 3'd2, 32'h20, 32'd0, 32'h1122_AB44, 1'b0, 3, 1, 1'b0, 32'd0);
      issue("sh_22",  1'b1, 3'd1, 32'h22, 32'h1234_CAFE, 32'd0, 1'b0, 4, 1, 1'b1, 32'hCAFE_AB44);
      // full-word store at the top of memory
      issue("sw_3c",  1'b1, 3'd2, 32'h3C, 32'hDEAD_BEEF, 32'd0, 1'b0, 2, 0, 1'b1, 32'hDEAD_BEEF);
      issue("lw_3c",  1'b0, 3'd2, 32'h3C, 32'd0, 32'hDEAD_BEEF, 1'b0, 3, 1, 1'b0, 32'd0);
      issue("lb_3f",  1'b0, 3'd0, 32'h3F, 32'd0, 32'hFFFF_FFDE, 1'b0, 3, 1, 1'b0, 32'd0);
      // error paths
      issue("lw_40",  1'b0, 3'd2, 32'h40, 32'd0, 32'd0, 1'b1, 1, 0, 1'b0, 32'd0);
      issue("ld_f3",  1'b0, 3'd3, 32'h10, 32'd0, 32'd0, 1'b1, 1, 0, 1'b0, 32'd0);
      issue("st_f4",  1'b1, 3'd4, 32'h10, 32'h55, 32'd0, 1'b1, 1, 0, 1'b0, 32'd0);
      issue("lw_3e",  1'b0, 3'd2, 32'h3E, 32'd0, 32'd0, 1'b1, 1, 0, 1'b0, 32'd0);
`ifdef LSU_MISALIGN_TRAP_EN
      issue("lh_11",  1'b0, 3'd1, 32'h11, 32'd0, 32'd0, 1'b1, 1, 0, 1'b0, 32'd0);
`else
      issue("lh_11",  1'b0, 3'd1, 32'h11, 32'd0, 32'h0000_00F0, 1'b0, 3, 1, 1'b0, 32'd0);
`endif

      // reset during WAIT of an SH: no write may follow
      wait_ready(ok);
      if (ok) begin
         exp_raddr  = 32'h20;
         req_valid  = 1'b1;
         req_we     = 1'b1;
         req_funct3 = 3'd1;
         req_addr   = 32'h20;
         req_wdata  = 32'h0000_5555;
         @(posedge clk);
         #1;
         req_valid = 1'b0;
         @(posedge clk);
         #1;
         rst_n = 1'b0;
         @(posedge clk);
         #1;
         chk_outputs_zero("abort");
         rst_n = 1'b1;
         @(posedge clk);
         #1;
         chk("abort_ready_rise", {31'd0, req_ready}, 32'd1);
         repeat (3) @(negedge clk);
         chk("abort_mem_kept", mem[8], 32'hCAFE_AB44);
      end
      issue("lw_20_after", 1'b0, 3'd2, 32'h20, 32'd0, 32'hCAFE_AB44, 1'b0, 3, 1, 1'b0, 32'd0);

      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/lsu_port.md
LSU_PORT -- requirements
Module: lsu_port

Interface
REQ-001 SHALL have parameter MEM_BYTES, default 64, meaning the data memory size in bytes; byte addresses at or above MEM_BYTES are out of range.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset; reset is synchronous and active-low.
REQ-004 SHALL have port req_valid, input, 1, CPU access request.
REQ-005 SHALL have port req_ready, output, 1, block can accept a request this cycle.
REQ-006 SHALL have port req_we, input, 1, 1 = store, 0 = load.
REQ-007 SHALL have port req_funct3, input, 3, RV32I width/sign code (LB=0, LH=1, LW=2, LBU=4, LHU=5; SB=0, SH=1, SW=2).
REQ-008 SHALL have port req_addr, input, 32, byte address.
REQ-009 SHALL have port req_wdata, input, 32, store data, right-aligned.
REQ-010 SHALL have port rsp_valid, output, 1, one-cycle completion pulse.
REQ-011 SHALL have port rsp_rdata, output, 32, load result, extended to 32 bits; 0 for stores and errors.
REQ-012 SHALL have port rsp_err, output, 1, access rejected; valid only with rsp_valid.
REQ-013 SHALL have port mem_addr, output, 32, word-aligned address to memory; bits [1:0] always 0.
REQ-014 SHALL have port mem_ren, output, 1, read strobe; memory returns data on mem_rdata in the following cycle.
REQ-015 SHALL have port mem_wen, output, 1, full-word write strobe.
REQ-016 SHALL have port mem_wdata, output, 32, word to write, little-endian lanes.
REQ-017 SHALL have port mem_rdata, input, 32, read word from memory.

Function
REQ-018 SHALL implement FSM states IDLE, READ, WAIT, WRITE, RESP, with all outputs registered.
REQ-019 SHALL assert req_ready only in IDLE; a request is accepted when req_valid && req_ready at a rising edge, which latches we, funct3, addr and wdata.
REQ-020 SHALL use these paths after accept:
- load: IDLE->READ->WAIT->RESP, with rsp_valid 3 cycles after the accept edge.
- SW: IDLE->WRITE->RESP.
- SB/SH: IDLE->READ->WAIT->WRITE->RESP (read-modify-write).
REQ-021 SHALL assert mem_ren only in READ and mem_wen only in WRITE; mem_addr = {addr[31:2],2'b00} in READ and in WRITE, and 0 otherwise.
REQ-022 SHALL capture mem_rdata into an internal word register in WAIT.
REQ-023 SHALL, for loads, take byte lane n = addr[1:0] (bits 8n+7:8n) and halfword lane addr[1]; sign-extend for LB/LH and zero-extend for LBU/LHU.
REQ-024 SHALL, for SB/SH, form mem_wdata as the captured word with only the addressed lane replaced by req_wdata[7:0] or req_wdata[15:0]; for SW, mem_wdata = req_wdata.
REQ-025 SHALL take the error path IDLE->RESP with rsp_err=1 and no mem_ren/mem_wen for any of:
- illegal funct3 (load 3/6/7; store 3-7);
- addr >= MEM_BYTES;
- addr + access size > MEM_BYTES.
REQ-026 SHALL hold rsp_valid for exactly one cycle (RESP) and then return to IDLE; there is no response backpressure.
REQ-027 SHALL ignore req_valid while not in IDLE, with no queuing.

Reset
REQ-028 SHALL, when rst_n is low at a rising edge, force state IDLE and clear req_ready, rsp_valid, rsp_err, rsp_rdata, mem_addr, mem_ren, mem_wen and mem_wdata to 0 during the following cycle; req_ready rises in the first cycle after rst_n is sampled high.
REQ-029 SHALL abandon any in-flight access on reset with no mem_wen afterward; a partially completed SB/SH RMW leaves memory unmodified.

Configuration
REQ-030 SHALL, with macro LSU_MISALIGN_TRAP_EN defined, treat LH/LHU/SH with addr[0]=1 and LW/SW with addr[1:0]!=0 as errors per REQ-025.
REQ-031 SHALL, without LSU_MISALIGN_TRAP_EN, ignore address bits below natural alignment: LH/LHU/SH use lane addr[1], and LW/SW ignore addr[1:0].

Verification
REQ-032 SHALL cover: memory word 0x8000_00F0 at addr 0x10; LB addr 0x10 -> rsp_rdata 0xFFFF_FFF0; LBU addr 0x10 -> 0x0000_00F0; LHU addr 0x12 -> 0x0000_8000; each response 3 cycles after accept.
REQ-033 SHALL cover: word 0x1122_3344 at addr 0x20; SB wdata 0xAB at addr 0x21 -> one mem_wen with mem_wdata 0x1122_AB44; rsp_valid 4 cycles after accept.
REQ-034 SHALL cover: SW 0xDEAD_BEEF at addr 0x3C -> mem_wen in the cycle after accept, and rsp_valid the cycle after that with rsp_err=0.
REQ-035 SHALL cover: LW addr 0x40 with MEM_BYTES=64, or load funct3=3 -> rsp_err=1 one cycle after accept, and no mem_ren/mem_wen.
REQ-036 SHALL cover: LH addr 0x11 -> rsp_err=1 with LSU_MISALIGN_TRAP_EN; without it, a normal response using lane 0.
REQ-037 SHALL cover: rst_n low during WAIT of an SH -> no mem_wen, outputs 0, and req_ready=1 one cycle after rst_n is sampled high.
